// File: rtl/button_conditioner.sv
// Two-button conditioner: per-button two-flop synchroniser, counter debounce and press strobe.
// Define HOLD_REPEAT_EN to add hold-to-repeat strobes after REPEAT_DELAY / REPEAT_PERIOD clocks.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 5_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btnS,
  input  logic btnR,
  output logic btnS_level,
  output logic btnR_level,
  output logic btnS_pulse,
  output logic btnR_pulse
);

  localparam int unsigned      CntW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0]  CntLast = CntW'(DEBOUNCE_CYCLES - 1);

`ifdef HOLD_REPEAT_EN
  localparam int unsigned      RptW       = $clog2(REPEAT_DELAY + 1);
  localparam logic [RptW-1:0]  DelayLast  = RptW'(REPEAT_DELAY - 1);
  localparam logic [RptW-1:0]  PeriodLast = RptW'(REPEAT_PERIOD - 1);
`else
  // Repeat timing has no effect in this build.
  localparam int unsigned      unused_repeat_cfg = REPEAT_DELAY ^ REPEAT_PERIOD;
`endif

  logic [1:0] raw;
  logic [1:0] level;
  logic [1:0] pulse;

  assign raw = {btnR, btnS};

  // Channel 0 is btnS, channel 1 is btnR; no state is shared between them.
  for (genvar ch = 0; ch < 2; ch = ch + 1) begin : g_chan
    logic            s1_q, s1_d;
    logic            s2_q, s2_d;
    logic            level_q, level_d;
    logic            pulse_q, pulse_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            press;

    always_comb begin
      s1_d    = raw[ch];
      s2_d    = s1_q;
      level_d = level_q;
      cnt_d   = '0;
      press   = 1'b0;
      if (s2_q != level_q) begin
        if (cnt_q == CntLast) begin
          level_d = ~level_q;
          press   = ~level_q;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    end

`ifdef HOLD_REPEAT_EN
    logic [RptW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic            rpt_periodic_q, rpt_periodic_d;
    logic            rpt_fire;

    // Restart on the press strobe; idle (and no repeat) whenever the level is or goes low.
    always_comb begin
      rpt_cnt_d      = rpt_cnt_q;
      rpt_periodic_d = rpt_periodic_q;
      rpt_fire       = 1'b0;
      if (press || !level_d) begin
        rpt_cnt_d      = '0;
        rpt_periodic_d = 1'b0;
      end else if (rpt_periodic_q ? (rpt_cnt_q == PeriodLast) : (rpt_cnt_q == DelayLast)) begin
        rpt_fire       = 1'b1;
        rpt_cnt_d      = '0;
        rpt_periodic_d = 1'b1;
      end else begin
        rpt_cnt_d = rpt_cnt_q + RptW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rpt_cnt_q      <= '0;
        rpt_periodic_q <= 1'b0;
      end else begin
        rpt_cnt_q      <= rpt_cnt_d;
        rpt_periodic_q <= rpt_periodic_d;
      end
    end

    assign pulse_d = press | rpt_fire;
`else
    assign pulse_d = press;
`endif

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_q    <= 1'b0;
        s2_q    <= 1'b0;
        cnt_q   <= '0;
        level_q <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        s1_q    <= s1_d;
        s2_q    <= s2_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        pulse_q <= pulse_d;
      end
    end

    assign level[ch] = level_q;
    assign pulse[ch] = pulse_q;
  end

  assign btnS_level = level[0];
  assign btnR_level = level[1];
  assign btnS_pulse = pulse[0];
  assign btnR_pulse = pulse[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=5; repeat expectations follow HOLD_REPEAT_EN.
module tb_button_conditioner;

  localparam int unsigned Db  = 4;
  localparam int unsigned Rd  = 10;
  localparam int unsigned Rp  = 5;
  localparam int unsigned Lat = Db + 1;  // edges from first s1 sample to the output change

  logic clk = 1'b0;
  logic rst, btnS, btnR;
  logic btnS_level, btnR_level, btnS_pulse, btnR_pulse;

  button_conditioner #(
    .DEBOUNCE_CYCLES(Db),
    .REPEAT_DELAY   (Rd),
    .REPEAT_PERIOD  (Rp)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btnS      (btnS),
    .btnR      (btnR),
    .btnS_level(btnS_level),
    .btnR_level(btnR_level),
    .btnS_pulse(btnS_pulse),
    .btnR_pulse(btnR_pulse)
  );

  always #5 clk = ~clk;

  int unsigned edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  // Event kinds: 0 S level, 1 R level, 2 S pulse, 3 R pulse.
  int unsigned exp_edge_q[4][$];
  bit          exp_val_q[4][$];

  function automatic string kname(input int k);
    case (k)
      0:       return "btnS_level";
      1:       return "btnR_level";
      2:       return "btnS_pulse";
      default: return "btnR_pulse";
    endcase
  endfunction

  task automatic push(input int k, input int unsigned e, input bit v);
    exp_edge_q[k].push_back(e);
    exp_val_q[k].push_back(v);
  endtask

  // e0: first edge sampling the raw high; er: first edge sampling the raw low.
  task automatic expect_hold(input int ch, input int unsigned e0, input int unsigned er);
    push(ch, e0 + Lat, 1'b1);
    push(ch + 2, e0 + Lat, 1'b1);
`ifdef HOLD_REPEAT_EN
    for (int unsigned r = e0 + Lat + Rd; r < er + Lat; r += Rp) push(ch + 2, r, 1'b1);
`endif
    push(ch, er + Lat, 1'b0);
  endtask

  task automatic observe(input int k, input logic v);
    int unsigned e;
    bit          ev;
    n_checks++;
    if (exp_edge_q[k].size() == 0) begin
      n_fail++;
      $display("FAIL %s: got value %b at edge %0d, required no event", kname(k), v, edge_n);
    end else begin
      e  = exp_edge_q[k].pop_front();
      ev = exp_val_q[k].pop_front();
      if (e != edge_n || v !== ev)
        begin
          n_fail++;
          $display("FAIL %s: got value %b at edge %0d, required value %b at edge %0d",
                   kname(k), v, edge_n, ev, e);
        end
    end
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every level change and every high pulse cycle consumes one expected event.
  logic prev_s = 1'b0;
  logic prev_r = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (btnS_level !== prev_s) begin
        observe(0, btnS_level);
        prev_s = btnS_level;
      end
      if (btnR_level !== prev_r) begin
        observe(1, btnR_level);
        prev_r = btnR_level;
      end
      if (btnS_pulse !== 1'b0) observe(2, btnS_pulse);
      if (btnR_pulse !== 1'b0) observe(3, btnR_pulse);
    end
  end

  int unsigned e0, f;

  initial begin
    rst  = 1'b1;
    btnS = 1'b0;
    btnR = 1'b0;
    step(2);
    chk("reset btnS_level", btnS_level, 1'b0);
    chk("reset btnR_level", btnR_level, 1'b0);
    chk("reset btnS_pulse", btnS_pulse, 1'b0);
    chk("reset btnR_pulse", btnR_pulse, 1'b0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Clean press held, then release.
    e0 = edge_n + 1;
    expect_hold(0, e0, e0 + 21);
    btnS = 1'b1;
    step(21);
    btnS = 1'b0;
    step(10);

    // Bounce shorter than the debounce window.
    btnS = 1'b1; step(3);
    btnS = 1'b0; step(1);
    btnS = 1'b1; step(3);
    btnS = 1'b0; step(8);
    chk("bounce btnS_level", btnS_level, 1'b0);
    chk("bounce btnS_pulse", btnS_pulse, 1'b0);

    // Simultaneous press of both buttons.
    e0 = edge_n + 1;
    expect_hold(0, e0, e0 + 8);
    expect_hold(1, e0, e0 + 8);
    btnS = 1'b1;
    btnR = 1'b1;
    step(8);
    btnS = 1'b0;
    btnR = 1'b0;
    step(10);

    // Reset while btnR's debounce count is at 2, button held through release of rst.
    e0   = edge_n + 1;
    btnR = 1'b1;
    step(4);
    rst = 1'b1;
    step(1);
    chk("midrst btnS_level", btnS_level, 1'b0);
    chk("midrst btnR_level", btnR_level, 1'b0);
    chk("midrst btnS_pulse", btnS_pulse, 1'b0);
    chk("midrst btnR_pulse", btnR_pulse, 1'b0);
    rst = 1'b0;
    f   = edge_n + 1;
    expect_hold(1, f, f + 12);
    step(12);
    btnR = 1'b0;
    step(10);

    // Long hold: 40+ clocks past the press pulse.
    e0 = edge_n + 1;
    expect_hold(0, e0, e0 + 43);
    btnS = 1'b1;
    step(43);
    btnS = 1'b0;
    step(12);

    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (exp_edge_q[k].size() != 0) begin
        n_fail++;
        $display("FAIL %s leftover: got %0d events missing, required 0 (next at edge %0d)",
                 kname(k), exp_edge_q[k].size(), exp_edge_q[k][0]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
